// File: rtl/ct_ifu_ind_btb_pkg.sv
// Shared widths, entry layout and controller state encoding for the
// indirect-branch BTB array controller.
package ct_ifu_ind_btb_pkg;

    localparam int INDEX_W = 8;
    localparam int TAG_W   = 6;
    localparam int TGT_W   = 16;
    // One valid bit plus tag plus target fills the 23-bit array word.
    localparam int ENTRY_W = 1 + TAG_W + TGT_W;

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        logic [TGT_W-1:0] target;
    } ind_btb_entry_t;

    typedef enum logic {
        INV  = 1'b0,
        IDLE = 1'b1
    } ind_btb_state_t;

    // Builds a valid entry from an update request.
    function automatic ind_btb_entry_t make_entry(input logic [TAG_W-1:0] tag,
                                                  input logic [TGT_W-1:0] target);
        ind_btb_entry_t e;
        e.vld    = 1'b1;
        e.tag    = tag;
        e.target = target;
        return e;
    endfunction

endpackage

// File: rtl/ct_ifu_ind_btb_wbuf.sv
// One-entry update buffer: holds the newest pending update until the array
// has a free cycle. A newer update simply replaces an older pending one.
module ct_ifu_ind_btb_wbuf
    import ct_ifu_ind_btb_pkg::*;
(
    input  logic                clk,
    input  logic                rst_b,
    input  logic                load,
    input  logic                clr,
    input  logic                drain,
    input  logic [INDEX_W-1:0]  upd_index,
    input  logic [TAG_W-1:0]    upd_tag,
    input  logic [TGT_W-1:0]    upd_target,
    output logic                wbuf_vld,
    output logic [INDEX_W-1:0]  wbuf_index,
    output ind_btb_entry_t      wbuf_entry
);

    // Valid flag: a flush beats a new load, a new load beats draining.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wbuf_vld <= 1'b0;
        end else if (clr) begin
            wbuf_vld <= 1'b0;
        end else if (load) begin
            wbuf_vld <= 1'b1;
        end else if (drain) begin
            wbuf_vld <= 1'b0;
        end
    end

    // Payload is only meaningful while wbuf_vld is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            wbuf_index <= upd_index;
            wbuf_entry <= make_entry(upd_tag, upd_target);
        end
    end

endmodule

// File: rtl/ct_ifu_ind_btb_ctrl.sv
// Indirect-branch BTB array controller: sweeps the array clear after reset or
// on CP0 request, arbitrates lookups over buffered updates, and turns the
// array read data into a hit/target response one cycle after each lookup.
module ct_ifu_ind_btb_ctrl
    import ct_ifu_ind_btb_pkg::*;
(
    input  logic                forever_cpuclk,
    input  logic                cpurst_b,
    input  logic                cp0_ifu_ind_btb_en,
    input  logic                cp0_ifu_ind_btb_inv,
    input  logic                pred_rd_vld,
    input  logic [INDEX_W-1:0]  pred_rd_index,
    input  logic [TAG_W-1:0]    pred_rd_tag,
    input  logic                upd_vld,
    input  logic [INDEX_W-1:0]  upd_index,
    input  logic [TAG_W-1:0]    upd_tag,
    input  logic [TGT_W-1:0]    upd_target,
    input  logic [ENTRY_W-1:0]  ind_btb_dout,
    output logic                ind_btb_cen_b,
    output logic                ind_btb_wen_b,
    output logic                ind_btb_clk_en,
    output logic [INDEX_W-1:0]  ind_btb_index,
    output logic [ENTRY_W-1:0]  ind_btb_data_in,
    output logic                rd_resp_vld,
    output logic                rd_hit,
    output logic [TGT_W-1:0]    rd_target,
    output logic                ind_btb_inv_busy
);

    ind_btb_state_t      state;
    logic [INDEX_W-1:0]  inv_cnt;

    logic                rd_acc;
    logic                wr_acc;
    logic                inv_start;
    logic                wbuf_load;
    logic                wbuf_clr;
    logic                wbuf_vld;
    logic [INDEX_W-1:0]  wbuf_index;
    ind_btb_entry_t      wbuf_entry;

    logic                vld_p1;
    logic                rd_acc_p1;
    logic [TAG_W-1:0]    rd_tag_p1;
    ind_btb_entry_t      dout_entry;

    // Lookups always win the array; the buffered write waits for a free cycle.
    assign rd_acc    = (state == IDLE) && pred_rd_vld && cp0_ifu_ind_btb_en;
    assign wr_acc    = (state == IDLE) && !rd_acc && cp0_ifu_ind_btb_en && wbuf_vld;
    assign inv_start = (state == IDLE) && cp0_ifu_ind_btb_inv;
    assign wbuf_load = (state == IDLE) && cp0_ifu_ind_btb_en && upd_vld && !inv_start;
    assign wbuf_clr  = inv_start || !cp0_ifu_ind_btb_en;

    ct_ifu_ind_btb_wbuf u_wbuf (
        .clk        (forever_cpuclk),
        .rst_b      (cpurst_b),
        .load       (wbuf_load),
        .clr        (wbuf_clr),
        .drain      (wr_acc),
        .upd_index  (upd_index),
        .upd_tag    (upd_tag),
        .upd_target (upd_target),
        .wbuf_vld   (wbuf_vld),
        .wbuf_index (wbuf_index),
        .wbuf_entry (wbuf_entry)
    );

    // Array port drive: sweep write, lookup read, buffered write, or idle.
    always_comb begin
        ind_btb_cen_b   = 1'b1;
        ind_btb_wen_b   = 1'b1;
        ind_btb_index   = '0;
        ind_btb_data_in = '0;
        if (state == INV) begin
            ind_btb_cen_b = 1'b0;
            ind_btb_wen_b = 1'b0;
            ind_btb_index = inv_cnt;
        end else if (rd_acc) begin
            ind_btb_cen_b = 1'b0;
            ind_btb_index = pred_rd_index;
        end else if (wr_acc) begin
            ind_btb_cen_b   = 1'b0;
            ind_btb_wen_b   = 1'b0;
            ind_btb_index   = wbuf_index;
            ind_btb_data_in = wbuf_entry;
        end
    end

    assign ind_btb_clk_en   = ~ind_btb_cen_b;
    assign ind_btb_inv_busy = (state == INV);

    // Sweep/normal FSM; a CP0 invalidate during a sweep is ignored.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state   <= INV;
            inv_cnt <= '0;
        end else begin
            case (state)
                INV: begin
                    inv_cnt <= inv_cnt + 1'b1;
                    if (inv_cnt == '1) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (cp0_ifu_ind_btb_inv) begin
                        state   <= INV;
                        inv_cnt <= '0;
                    end
                end
                default: begin
                    state   <= INV;
                    inv_cnt <= '0;
                end
            endcase
        end
    end

    // ---- stage p0 -> p1: remember which lookups actually reached the array
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            vld_p1    <= 1'b0;
            rd_acc_p1 <= 1'b0;
        end else begin
            vld_p1    <= pred_rd_vld;
            rd_acc_p1 <= rd_acc;
        end
    end

    // Lookup tag rides alongside; only consulted when rd_acc_p1 is set.
    always_ff @(posedge forever_cpuclk) begin
        rd_tag_p1 <= pred_rd_tag;
    end

    // ---- stage p1: compare array data against the registered lookup tag
    assign dout_entry  = ind_btb_entry_t'(ind_btb_dout);
    assign rd_resp_vld = vld_p1;
    assign rd_hit      = rd_acc_p1 && dout_entry.vld && (dout_entry.tag == rd_tag_p1);
    assign rd_target   = rd_hit ? dout_entry.target : '0;

endmodule

// File: tb/tb_ct_ifu_ind_btb_ctrl.sv
// Self-checking bench for the indirect-branch BTB array controller: a
// behavioural SRAM answers the DUT, and a reference model predicts every
// array access and lookup response.
module tb_ct_ifu_ind_btb_ctrl;

    logic        clk;
    logic        cpurst_b;
    logic        en, inv;
    logic        rv;
    logic [7:0]  ri;
    logic [5:0]  rt;
    logic        uv;
    logic [7:0]  ui;
    logic [5:0]  ut;
    logic [15:0] ug;
    logic [22:0] dout;
    logic        cen_b, wen_b, clk_en;
    logic [7:0]  idx;
    logic [22:0] din;
    logic        resp_vld, hit, busy;
    logic [15:0] tgt;

    int n_chk = 0;
    int n_err = 0;

    ct_ifu_ind_btb_ctrl dut (
        .forever_cpuclk      (clk),
        .cpurst_b            (cpurst_b),
        .cp0_ifu_ind_btb_en  (en),
        .cp0_ifu_ind_btb_inv (inv),
        .pred_rd_vld         (rv),
        .pred_rd_index       (ri),
        .pred_rd_tag         (rt),
        .upd_vld             (uv),
        .upd_index           (ui),
        .upd_tag             (ut),
        .upd_target          (ug),
        .ind_btb_dout        (dout),
        .ind_btb_cen_b       (cen_b),
        .ind_btb_wen_b       (wen_b),
        .ind_btb_clk_en      (clk_en),
        .ind_btb_index       (idx),
        .ind_btb_data_in     (din),
        .rd_resp_vld         (resp_vld),
        .rd_hit              (hit),
        .rd_target           (tgt),
        .ind_btb_inv_busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 256x23 array driven by the DUT.
    logic [22:0] sram [256];
    int          vwr_cnt [256];
    logic [7:0]  last_wr_idx;
    logic [22:0] last_wr_data;

    always @(posedge clk) begin
        if (!cen_b) begin
            if (!wen_b) begin
                sram[idx]    <= din;
                last_wr_idx  <= idx;
                last_wr_data <= din;
                if (din[22]) vwr_cnt[idx] <= vwr_cnt[idx] + 1;
            end else begin
                dout <= sram[idx];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model state.
    bit          m_sweep;
    int          m_cnt;
    bit          p_vld;
    logic [7:0]  p_idx;
    logic [5:0]  p_tag;
    logic [15:0] p_tgt;
    logic [22:0] ref_mem [256];
    bit          r_vld, r_acc;
    logic [22:0] r_entry;
    logic [5:0]  r_tag;

    task automatic model_reset();
        m_sweep = 1; m_cnt = 0; p_vld = 0; r_vld = 0; r_acc = 0;
    endtask

    // One clock: drive, check against the model, advance the model.
    task automatic cycle(input bit a_rv, input logic [7:0] a_ri, input logic [5:0] a_rt,
                         input bit a_uv, input logic [7:0] a_ui, input logic [5:0] a_ut,
                         input logic [15:0] a_ug, input bit a_en, input bit a_inv);
        bit e_cen, e_wen, e_hit, did_rd, wrote;
        logic [7:0]  e_idx;
        logic [22:0] e_dat;
        @(negedge clk);
        rv = a_rv; ri = a_ri; rt = a_rt; uv = a_uv; ui = a_ui; ut = a_ut; ug = a_ug;
        en = a_en; inv = a_inv;
        #1;
        e_hit = r_acc && r_entry[22] && (r_entry[21:16] == r_tag);
        chk("resp_vld", resp_vld, r_vld);
        chk("rd_hit", hit, e_hit);
        chk("rd_target", tgt, e_hit ? r_entry[15:0] : 16'h0);
        chk("inv_busy", busy, m_sweep);
        e_cen = 1; e_wen = 1; e_idx = 0; e_dat = 0; did_rd = 0; wrote = 0;
        if (m_sweep) begin
            e_cen = 0; e_wen = 0; e_idx = m_cnt[7:0];
        end else if (a_rv && a_en) begin
            e_cen = 0; e_idx = a_ri; did_rd = 1;
        end else if (a_en && p_vld) begin
            e_cen = 0; e_wen = 0; e_idx = p_idx; e_dat = {1'b1, p_tag, p_tgt}; wrote = 1;
        end
        chk("cen_b", cen_b, e_cen);
        chk("wen_b", wen_b, e_wen);
        chk("index", idx, e_idx);
        chk("data_in", din, e_dat);
        chk("clk_en", clk_en, !e_cen);
        r_vld = a_rv; r_acc = did_rd; r_tag = a_rt; r_entry = ref_mem[a_ri];
        if (!e_cen && !e_wen) ref_mem[e_idx] = e_dat;
        if (m_sweep) begin
            if (m_cnt == 255) begin m_sweep = 0; m_cnt = 0; end
            else m_cnt++;
        end else if (a_inv) begin
            m_sweep = 1; m_cnt = 0; p_vld = 0;
        end else if (!a_en) begin
            p_vld = 0;
        end else if (a_uv) begin
            p_vld = 1; p_idx = a_ui; p_tag = a_ut; p_tgt = a_ug;
        end else if (wrote) begin
            p_vld = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic lookup(input logic [7:0] i, input logic [5:0] t);
        cycle(1, i, t, 0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin ref_mem[i] = '1; vwr_cnt[i] = 0; end
        rv = 0; ri = 0; rt = 0; uv = 0; ui = 0; ut = 0; ug = 0; en = 1; inv = 0;
        cpurst_b = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_vld", resp_vld, 0);
        chk("rst_hit", hit, 0);
        chk("rst_target", tgt, 0);
        chk("rst_busy", busy, 1);
        chk("rst_index", idx, 0);
        chk("rst_cen_b", cen_b, 0);
        @(posedge clk); #2;
        cpurst_b = 1;

        // Power-up sweep of all 256 entries.
        idle(256);
        chk("t1_busy_fall", busy, 0);
        chk("t1_last_idx", last_wr_idx, 8'hFF);
        chk("t1_last_data", last_wr_data, 0);

        // Update then lookup hit/miss.
        cycle(0, 0, 0, 1, 8'h12, 6'h2A, 16'hBEEF, 1, 0);
        idle(1);
        chk("t2_wr_idx", last_wr_idx, 8'h12);
        chk("t2_wr_data", last_wr_data, 23'h6ABEEF);
        lookup(8'h12, 6'h2A);
        chk("t2_resp", resp_vld, 1);
        chk("t2_hit", hit, 1);
        chk("t2_target", tgt, 16'hBEEF);
        lookup(8'h12, 6'h2B);
        chk("t2_miss_hit", hit, 0);
        chk("t2_miss_target", tgt, 0);

        // Lookups hold off a pending write.
        cycle(1, 8'h41, 0, 1, 8'h40, 6'h03, 16'h4040, 1, 0);
        for (int i = 0; i < 4; i++) lookup(8'h41, 0);
        chk("t3_blocked", vwr_cnt[8'h40], 0);
        idle(1);
        chk("t3_written", vwr_cnt[8'h40], 1);

        // Back-to-back updates: the older one is dropped.
        cycle(1, 8'h30, 0, 1, 8'h01, 6'h05, 16'h1111, 1, 0);
        cycle(1, 8'h30, 0, 1, 8'h02, 6'h05, 16'h2222, 1, 0);
        idle(1);
        chk("t4_only_new", vwr_cnt[8'h01], 0);
        chk("t4_new_wr", last_wr_idx, 8'h02);
        lookup(8'h01, 6'h05);
        chk("t4_old_miss", hit, 0);
        lookup(8'h02, 6'h05);
        chk("t4_new_hit", hit, 1);

        // CP0 invalidate sweep with a lookup inside it.
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("t5_busy", busy, 1);
        lookup(8'h12, 6'h2A);
        chk("t5_sweep_resp", resp_vld, 1);
        chk("t5_sweep_hit", hit, 0);
        for (int i = 0; i < 300 && m_sweep; i++) idle(1);
        chk("t5_sweep_done", busy, 0);
        lookup(8'h12, 6'h2A);
        chk("t5_post_miss", hit, 0);

        // Disabled: no array access, update dropped.
        cycle(1, 8'h55, 6'h01, 1, 8'h55, 6'h01, 16'h5555, 0, 0);
        chk("t6_dis_resp", resp_vld, 1);
        chk("t6_dis_hit", hit, 0);
        idle(2);
        chk("t6_buf_empty", vwr_cnt[8'h55], 0);

        // Reset in the middle of a sweep restarts at index 0.
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(100);
        @(negedge clk); #1;
        chk("t6_cnt100", idx, 8'd100);
        cpurst_b = 0;
        model_reset();
        #1;
        chk("t6_rst_idx", idx, 0);
        @(posedge clk); @(posedge clk); #2;
        cpurst_b = 1;
        idle(256);
        chk("t6_resweep_done", busy, 0);

        // Randomized traffic over a small index/tag space to get hits.
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 1), 8'($urandom_range(0, 7)), 6'($urandom_range(0, 3)),
                  $urandom_range(0, 2) == 0, 8'($urandom_range(0, 7)), 6'($urandom_range(0, 3)),
                  16'($urandom), $urandom_range(0, 15) != 0, $urandom_range(0, 399) == 0);
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
